// File: rtl/pc_seq_unit_if.sv
// pc_seq_unit_if: fetch/execute handshake and PC/RAS status bundle for pc_seq_unit
interface pc_seq_unit_if #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
);
    logic                               instr_valid;
    logic                               stall;
    logic [15:0]                        instr;
    logic [WIDTH-1:0]                   alu_out;
    logic [WIDTH-1:0]                   brj_dest;
    logic                               bt;
    logic [WIDTH-1:0]                   pc;
    logic [WIDTH-1:0]                   next_pc;
    logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count;
    logic                               ras_mismatch;
    logic                               ras_overflow;
    logic [WIDTH-1:0]                   epc;

    modport master (
        output instr_valid, stall, instr, alu_out, brj_dest, bt,
        input  pc, next_pc, ras_count, ras_mismatch, ras_overflow, epc
    );

    modport slave (
        input  instr_valid, stall, instr, alu_out, brj_dest, bt,
        output pc, next_pc, ras_count, ras_mismatch, ras_overflow, epc
    );
endinterface

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: registered PC with next-PC select, advisory return-address stack and
// optional SIIC/RTI exception return state (enabled by defining PC_EXCEPTION_EN).
module pc_seq_unit #(
    parameter int          WIDTH      = 16,
    parameter int          RAS_DEPTH  = 4,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned EXC_VECTOR = 16'h0002
) (
    input logic          clk,
    input logic          rst,
    pc_seq_unit_if.slave bus
);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] EXC_VAL = WIDTH'(EXC_VECTOR);
    localparam logic [4:0] OP_SIIC = 5'b00010, OP_RTI = 5'b00011, OP_J = 5'b00100,
                           OP_JR = 5'b00101, OP_JAL = 5'b00110, OP_JALR = 5'b00111,
                           OP_BEQZ = 5'b01100, OP_BNEZ = 5'b01101, OP_RET = 5'b01110,
                           OP_BLTZ = 5'b01111;

    logic [4:0]       op;
    logic             commit, is_br, is_jmp, is_push, is_ret, is_rti, is_siic, full;
    logic [WIDTH-1:0] pc, pc_inc, target, rti_target, epc;
    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    top, top_inc, top_dec;
    logic [CW-1:0]    count;
    logic             mismatch, overflow;
    logic             unused_ok;

    assign op        = bus.instr[15:11];
    assign unused_ok = ^bus.instr[10:0];
    assign commit    = bus.instr_valid && !bus.stall;
    assign is_br     = op == OP_BEQZ || op == OP_BNEZ || op == OP_BLTZ;
    assign is_jmp    = op == OP_J || op == OP_JR || op == OP_JAL || op == OP_JALR;
    assign is_push   = op == OP_JAL || op == OP_JALR;
    assign is_ret    = op == OP_RET;
    assign is_rti    = op == OP_RTI;
    assign full      = count == CW'(RAS_DEPTH);
    assign top_inc   = (top == PW'(RAS_DEPTH - 1)) ? '0 : top + PW'(1);
    assign top_dec   = (top == '0) ? PW'(RAS_DEPTH - 1) : top - PW'(1);

`ifdef PC_EXCEPTION_EN
    assign is_siic    = op == OP_SIIC;
    assign rti_target = epc;
    always_ff @(posedge clk) begin
        if (rst)
            epc <= '0;
        else if (commit && is_siic)
            epc <= pc_inc;
    end
`else
    assign is_siic    = 1'b0;
    assign rti_target = bus.alu_out;
    assign epc        = '0;
`endif

    always_comb begin
        pc_inc = pc + WIDTH'(2);
        target = is_jmp  ? bus.brj_dest :
                 is_br   ? (bus.bt ? bus.brj_dest : pc_inc) :
                 is_ret  ? bus.alu_out :
                 is_rti  ? rti_target :
                 is_siic ? EXC_VAL : pc_inc;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc <= RST_VAL;
        else if (commit)
            pc <= target;
    end

    // Circular stack: when full, top already points at the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (!rst && commit && is_push)
            ras[top] <= pc_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top      <= '0;
            count    <= '0;
            mismatch <= 1'b0;
            overflow <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            overflow <= 1'b0;
            if (commit && is_push) begin
                top      <= top_inc;
                count    <= full ? count : count + CW'(1);
                overflow <= full;
            end else if (commit && is_ret) begin
                if (count != '0) begin
                    top      <= top_dec;
                    count    <= count - CW'(1);
                    mismatch <= ras[top_dec] != bus.alu_out;
                end else begin
                    mismatch <= 1'b1;
                end
            end
        end
    end

    assign bus.pc           = pc;
    assign bus.next_pc      = commit ? target : pc;
    assign bus.ras_count    = count;
    assign bus.ras_mismatch = mismatch;
    assign bus.ras_overflow = overflow;
    assign bus.epc          = epc;
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: scoreboard bench for pc_seq_unit; a behavioural PC/RAS model queues
// the expected state per cycle and each scenario task pops and compares it after the edge.
module tb_pc_seq_unit;
    localparam logic [4:0] ADD = 5'b11011, SIIC = 5'b00010, RTI = 5'b00011, J = 5'b00100,
                           JR = 5'b00101, JAL = 5'b00110, JALR = 5'b00111, BEQZ = 5'b01100,
                           BNEZ = 5'b01101, RET = 5'b01110, BLTZ = 5'b01111;

    typedef struct packed {
        logic [15:0] nxt;
        logic [15:0] pc;
        logic [2:0]  cnt;
        logic        mm;
        logic        ov;
        logic [15:0] epc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_seq_unit_if #(.WIDTH(16), .RAS_DEPTH(4)) bus ();

    pc_seq_unit #(.WIDTH(16), .RAS_DEPTH(4), .RESET_PC(0), .EXC_VECTOR(16'h0002)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    obs_t        sb[$];
    logic [15:0] m_ras[$];
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_epc = 16'h0000;
    logic [15:0] obs_nxt;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic obs_t sample();
        return '{obs_nxt, bus.pc, bus.ras_count, bus.ras_mismatch, bus.ras_overflow, bus.epc};
    endfunction

    // Applies one cycle of stimulus, advances the model and queues the expected outcome.
    task automatic drive(input logic r, input logic v, input logic s, input logic [4:0] op,
                         input logic [15:0] alu, input logic [15:0] brj, input logic b);
        logic [15:0] inc, tgt, nxt, popped;
        logic        mm, ov;
        @(negedge clk);
        rst = r;
        bus.instr_valid = v;
        bus.stall = s;
        bus.instr = {op, 11'h000};
        bus.alu_out = alu;
        bus.brj_dest = brj;
        bus.bt = b;
        inc = m_pc + 16'd2;
        case (op)
            BEQZ, BNEZ, BLTZ: tgt = b ? brj : inc;
            J, JR, JAL, JALR: tgt = brj;
            RET:              tgt = alu;
`ifdef PC_EXCEPTION_EN
            RTI:              tgt = m_epc;
            SIIC:             tgt = 16'h0002;
`else
            RTI:              tgt = alu;
`endif
            default:          tgt = inc;
        endcase
        nxt = (v && !s) ? tgt : m_pc;
        mm = 1'b0;
        ov = 1'b0;
        if (r) begin
            m_pc = 16'h0000;
            m_epc = 16'h0000;
            m_ras.delete();
        end else if (v && !s) begin
            if (op == JAL || op == JALR) begin
                if (m_ras.size() == 4) begin
                    popped = m_ras.pop_front();
                    ov = 1'b1;
                end
                m_ras.push_back(inc);
            end else if (op == RET) begin
                if (m_ras.size() > 0) begin
                    popped = m_ras.pop_back();
                    mm = popped != alu;
                end else begin
                    mm = 1'b1;
                end
            end
`ifdef PC_EXCEPTION_EN
            if (op == SIIC) m_epc = inc;
`endif
            m_pc = nxt;
        end
        sb.push_back('{nxt, m_pc, 3'(m_ras.size()), mm, ov, m_epc});
        #1 obs_nxt = bus.next_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        drive(1, 0, 0, ADD, 16'h0, 16'h0, 0);
        drive(1, 1, 0, ADD, 16'h0, 16'h0, 0);
        for (int i = 0; i < 2; i++) begin
            o = sample();
            e = sb.pop_front();
            o.nxt = 16'h0;
            e.nxt = 16'h0;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset[%0d]: got %p want %p", i, o, e); end
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        obs_t o, e;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, i == 3, ADD, 16'h0, 16'h0, 0);
            o = sample();
            e = sb.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL seq[%0d]: got %p want %p", i, o, e); end
        end
        n_checks++;
        if (bus.pc !== 16'h0006) begin n_fail++; $display("FAIL stall_hold: got %h want 0006", bus.pc); end
    endtask

    task automatic test_branch();
        obs_t o, e;
        logic [4:0] ops[6] = '{J, BEQZ, J, BEQZ, BLTZ, BNEZ};
        logic [15:0] dst[6] = '{16'h0010, 16'h0040, 16'h0010, 16'h0040, 16'h0070, 16'h0090};
        logic bts[6] = '{0, 0, 0, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, ops[i], 16'h0, dst[i], bts[i]);
            o = sample();
            e = sb.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL branch[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    task automatic test_ras_return();
        obs_t o, e;
        logic [4:0] ops[5] = '{J, JAL, RET, RET, ADD};
        logic [15:0] dst[5] = '{16'h0020, 16'h0100, 16'h0, 16'h0, 16'h0};
        logic [15:0] alu[5] = '{16'h0, 16'h0, 16'h0022, 16'h0050, 16'h0};
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, ops[i], alu[i], dst[i], 0);
            o = sample();
            e = sb.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL ras[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    task automatic test_overflow();
        obs_t o, e;
        for (int k = 0; k < 6; k++) begin
            drive(0, k < 5, 0, JAL, 16'h0, 16'h0200 + 16'(k * 16), 0);
            o = sample();
            e = sb.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL ovf_push[%0d]: got %p want %p", k, o, e); end
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, RET, (k < 4) ? 16'h0232 - 16'(k * 16) : 16'h0123, 16'h0, 0);
            o = sample();
            e = sb.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL ovf_pop[%0d]: got %p want %p", k, o, e); end
        end
    endtask

    task automatic test_exception();
        obs_t o, e;
        logic [4:0] ops[4] = '{J, SIIC, RTI, ADD};
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, ops[i], 16'h9999, 16'h0030, 0);
            o = sample();
            e = sb.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL exc[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic [4:0] ops[6] = '{ADD, JR, JALR, BNEZ, BLTZ, RET};
        logic [15:0] dst[6] = '{16'h0, 16'h0080, 16'h0090, 16'h00A0, 16'h00F0, 16'h0};
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, ops[i], 16'h0082, dst[i], i == 3);
            o = sample();
            e = sb.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL b2b[%0d]: got %p want %p", i, o, e); end
        end
    endtask

    task automatic test_wrap_and_reset_priority();
        obs_t o, e;
        logic [4:0] ops[5] = '{J, ADD, JAL, J, ADD};
        logic [15:0] dst[5] = '{16'hFFFE, 16'h0, 16'h0400, 16'h0300, 16'h0};
        for (int i = 0; i < 5; i++) begin
            drive(i == 3, 1, 0, ops[i], 16'h0, dst[i], 0);
            o = sample();
            e = sb.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL wrap_rst[%0d]: got %p want %p", i, o, e); end
        end
        n_checks++;
        if (bus.pc !== 16'h0002) begin n_fail++; $display("FAIL post_reset_pc: got %h want 0002", bus.pc); end
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.stall = 1'b0;
        bus.instr = 16'h0;
        bus.alu_out = 16'h0;
        bus.brj_dest = 16'h0;
        bus.bt = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_ras_return();
        test_overflow();
        test_exception();
        test_back_to_back();
        test_wrap_and_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_seq_unit.md
# pc_seq_unit

Registered program-counter unit with a parametrised return-address stack (RAS) and optional exception return state. It sits at the fetch/execute boundary and owns the architectural PC. Each cycle it selects the next PC from sequential, branch, jump, return and trap sources, and commits that PC under a valid/stall handshake. The RAS shadows JAL/JALR/RET and flags return-target mispredictions for later prediction work.

## Interface
- WIDTH, 16, PC/data width in bits (≥ 8)
- RAS_DEPTH, 4, return-address-stack entries (≥ 2)
- RESET_PC, 0, PC value loaded on reset
- EXC_VECTOR, 16'h0002, trap target; zero-extended or truncated to WIDTH
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- instr_valid  input  1  instr/alu_out/brj_dest/bt are valid this cycle
- stall  input  1  hold PC and all state this cycle
- instr  input  16  instruction; opcode = instr[15:11]
- alu_out  input  WIDTH  register-indirect return target (RET, non-exception RTI)
- brj_dest  input  WIDTH  computed branch/jump destination
- bt  input  1  branch condition true
- pc  output  WIDTH  current committed PC (registered)
- next_pc  output  WIDTH  combinational PC to be committed at next edge
- ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries
- ras_mismatch  output  1  one-cycle pulse: RET target differed from RAS top, or RAS empty
- ras_overflow  output  1  one-cycle pulse: push while full
- epc  output  WIDTH  saved exception return PC

## Operation
- pc_inc = pc + 2, modulo 2^WIDTH.
- Opcode → next_pc selection:
  - BEQZ 01100, BNEZ 01101, BLTZ 01111: bt ? brj_dest : pc_inc
  - J 00100, JR 00101, JAL 00110, JALR 00111: brj_dest
  - RET 01110: alu_out
  - RTI 00011: alu_out (see Configuration)
  - all others: pc_inc
- Commit condition: instr_valid && !stall. On commit, pc <= next_pc. Without commit, next_pc = pc, and pc, RAS, epc and pulses are unchanged or zero.
- RAS, on commit only:
  - JAL/JALR push pc_inc.
  - Push when count == RAS_DEPTH overwrites the oldest entry (circular), count stays at RAS_DEPTH, and ras_overflow pulses.
  - RET pops when count > 0. ras_mismatch pulses if the popped value != alu_out.
  - RET with count == 0: no pop, count stays 0, ras_mismatch pulses.
  - The RAS never alters next_pc; it is advisory only.
- Reset values: pc = RESET_PC, ras_count = 0, ras_mismatch = 0, ras_overflow = 0, epc = 0, RAS storage don't-care.

## Timing
- next_pc is combinational from pc, instr, bt, brj_dest, alu_out, instr_valid and stall; it has no registered latency.
- pc, ras_count and epc update at the rising edge after a commit cycle.
- ras_mismatch and ras_overflow are registered. Each is high for exactly the one cycle after the committing edge.
- rst has priority over commit. Reset asserted mid-sequence discards the pending commit, so pc = RESET_PC on the following cycle.
- stall takes priority over instr_valid. Back-to-back commits are allowed every cycle.

## Configuration
- PC_EXCEPTION_EN defined:
  - Opcode 00010 (SIIC) on commit sets epc <= pc_inc and next_pc = EXC_VECTOR.
  - RTI selects next_pc = epc instead of alu_out.
  - SIIC does not touch the RAS.
- PC_EXCEPTION_EN undefined:
  - SIIC follows the default path (pc_inc).
  - RTI selects alu_out.
  - epc is tied to 0 and no epc register is built.

## Test plan
- Reset, then 3 commits of ADD-type opcode 11011 with WIDTH=16, RESET_PC=0 → pc = 0, 2, 4, 6. Next, assert stall with instr_valid=1 → pc holds at 6.
- At pc=0x0010, issue BEQZ with brj_dest=0x0040. With bt=0 → pc=0x0012. Repeat with bt=1 → pc=0x0040.
- At pc=0x0020, JAL with brj_dest=0x0100 → pc=0x0100 and ras_count=1. Then RET with alu_out=0x0022 → pc=0x0022, ras_count=0, ras_mismatch=0. Another RET with alu_out=0x0050 → pc=0x0050 and ras_mismatch pulses one cycle.
- RAS_DEPTH=4, issue 5 JALs → ras_overflow pulses on the 5th and ras_count=4. Then 4 RETs with matching alu_out → the oldest pushed value is lost and no mismatch is reported on the first 4 pops.
- With PC_EXCEPTION_EN: at pc=0x0030, SIIC → pc=EXC_VECTOR=0x0002 and epc=0x0032. Then RTI with alu_out=0x9999 → pc=0x0032. Without PC_EXCEPTION_EN, the same sequence gives pc=0x0032 after SIIC, pc=0x9999 after RTI, and epc=0.
- WIDTH=16, pc=0xFFFE, default opcode → pc wraps to 0x0000. Assert rst on the same cycle as a J commit → pc=RESET_PC.
